cmplx_matmul_result_engine: RTL

Parametrised successor of the complex matrix-product result path. It sequences row/column operand fetches from the Q_RAM-style operand memories and computes each complex coefficient C[i][j] = sum_k A[i][k]*B[k][j] in two passes (real, then imaginary) over shared fixed-point multipliers. Each result is saturated, written into an internal DIM x DIM result RAM, and mirrored on a write-strobe port for downstream consumers. It adds start/busy/done handshaking, saturation, and a readback port.

---
 rtl/cmplx_matmul_result_engine.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/cmplx_matmul_result_engine.sv
// Complex N x N matrix product C = A*B, one coefficient per 4 cycles (FETCH, CALC_RE, CALC_IM, WRITE).
// Latency: coefficient n commits 4n+4 edges after the start edge; done pulses on edge 4*N*N.
// No backpressure: the write-strobe port is fire-and-forget; start is ignored while busy.
module cmplx_matmul_result_engine #(
  parameter int WORD_LEN   = 16,
  parameter int FRAC_BITS  = 8,
  parameter int MATRIX_DIM = 4,
  localparam int ADDR_BITS = $clog2(MATRIX_DIM)
) (
  input  logic                             src_clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             sat_flag,
  output logic [ADDR_BITS-1:0]             op_addr_a,
  output logic [ADDR_BITS-1:0]             op_addr_b,
  input  logic [WORD_LEN*MATRIX_DIM-1:0]   a_real,
  input  logic [WORD_LEN*MATRIX_DIM-1:0]   a_imag,
  input  logic [WORD_LEN*MATRIX_DIM-1:0]   b_real,
  input  logic [WORD_LEN*MATRIX_DIM-1:0]   b_imag,
  output logic                             wr_valid,
  output logic [2*ADDR_BITS-1:0]           wr_addr,
  output logic [WORD_LEN-1:0]              wr_real,
  output logic [WORD_LEN-1:0]              wr_imag,
  input  logic [2*ADDR_BITS-1:0]           res_rd_addr,
  output logic [WORD_LEN-1:0]              res_rd_real,
  output logic [WORD_LEN-1:0]              res_rd_imag
);

  localparam int N     = MATRIX_DIM;
  localparam int W     = WORD_LEN;
  localparam int F     = FRAC_BITS;
  localparam int PW    = 2 * W - F;              // meaningful width of a shifted product
  localparam int ACC_W = PW + ADDR_BITS + 2;      // holds sum of 2N products without overflow
  localparam int RA    = 2 * ADDR_BITS;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0]            POS_W   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]            NEG_W   = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CALC_RE,
    S_CALC_IM,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                   state;
  logic [ADDR_BITS-1:0]     row;
  logic [ADDR_BITS-1:0]     col;
  logic signed [ACC_W-1:0]  acc_re;

  logic signed [W-1:0]      mul_x    [2*N];
  logic signed [W-1:0]      mul_y    [2*N];
  logic signed [2*W-1:0]    prod     [2*N];
  logic signed [ACC_W-1:0]  prod_ext [2*N];
  logic signed [ACC_W-1:0]  sum_lo;
  logic signed [ACC_W-1:0]  sum_hi;
  logic signed [ACC_W-1:0]  acc_sum;
  logic                     calc_re;

  logic [W-1:0]             sat_re;
  logic [W-1:0]             sat_im;
  logic                     re_clamp;
  logic                     im_clamp;

  logic [2*W-1:0]           ram [N*N];

  // Operand indices stay on the current (i,j) from FETCH through WRITE.
  assign op_addr_a = row;
  assign op_addr_b = col;
  assign calc_re   = (state == S_CALC_RE);

  // Shared multiplier bank: low half takes A.re, high half takes A.im; the B operand
  // swaps between passes so the same 2N multipliers serve both real and imaginary sums.
  always_comb begin
    mul_x    = '{default: '0};
    mul_y    = '{default: '0};
    prod     = '{default: '0};
    prod_ext = '{default: '0};
    sum_lo   = '0;
    sum_hi   = '0;
    for (int k = 0; k < N; k++) begin
      mul_x[k]     = a_real[k*W +: W];
      mul_y[k]     = calc_re ? b_real[k*W +: W] : b_imag[k*W +: W];
      mul_x[N+k]   = a_imag[k*W +: W];
      mul_y[N+k]   = calc_re ? b_imag[k*W +: W] : b_real[k*W +: W];
    end
    for (int m = 0; m < 2*N; m++) begin
      prod[m]     = (2*W)'(mul_x[m]) * (2*W)'(mul_y[m]);
      // Arithmetic shift floors toward -inf; no per-product rounding.
      prod_ext[m] = ACC_W'(prod[m] >>> F);
    end
    for (int k = 0; k < N; k++) begin
      sum_lo = sum_lo + prod_ext[k];
      sum_hi = sum_hi + prod_ext[N+k];
    end
    acc_sum = calc_re ? (sum_lo - sum_hi) : (sum_lo + sum_hi);
  end

  // Clamp both parts to the signed word range; acc_sum is the imaginary sum during CALC_IM.
  always_comb begin
    sat_re   = acc_re[W-1:0];
    re_clamp = 1'b0;
    sat_im   = acc_sum[W-1:0];
    im_clamp = 1'b0;
    if (acc_re > SAT_MAX) begin
      sat_re   = POS_W;
      re_clamp = 1'b1;
    end else if (acc_re < SAT_MIN) begin
      sat_re   = NEG_W;
      re_clamp = 1'b1;
    end
    if (acc_sum > SAT_MAX) begin
      sat_im   = POS_W;
      im_clamp = 1'b1;
    end else if (acc_sum < SAT_MIN) begin
      sat_im   = NEG_W;
      im_clamp = 1'b1;
    end
  end

  // Sequencer with registered status and write-strobe outputs.
  always_ff @(posedge src_clk) begin
    if (rst) begin
      state    <= S_IDLE;
      row      <= '0;
      col      <= '0;
      acc_re   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sat_flag <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_real  <= '0;
      wr_imag  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            busy     <= 1'b1;
            sat_flag <= 1'b0;
            row      <= '0;
            col      <= '0;
          end
        end
        S_FETCH: begin
          state <= S_CALC_RE;
        end
        S_CALC_RE: begin
          acc_re <= acc_sum;
          state  <= S_CALC_IM;
        end
        S_CALC_IM: begin
          wr_valid <= 1'b1;
          wr_addr  <= {row, col};
          wr_real  <= sat_re;
          wr_imag  <= sat_im;
          if (re_clamp || im_clamp) begin
            sat_flag <= 1'b1;
          end
          state <= S_WRITE;
        end
        S_WRITE: begin
          wr_valid   <= 1'b0;
          // Row-major walk; the concatenated index wraps to zero after the last coefficient.
          {row, col} <= {row, col} + RA'(1);
          if (&{row, col}) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Result RAM commits at the edge that ends WRITE; contents survive reset.
  always_ff @(posedge src_clk) begin
    if (!rst && state == S_WRITE) begin
      ram[wr_addr] <= {wr_real, wr_imag};
    end
  end

  // Registered readback; a same-cycle write to the same address returns the old word.
  always_ff @(posedge src_clk) begin
    if (rst) begin
      res_rd_real <= '0;
      res_rd_imag <= '0;
    end else begin
      {res_rd_real, res_rd_imag} <= ram[res_rd_addr];
    end
  end

endmodule
